// File: rtl/vga_rx.sv
// VGA receiver: locks onto HS/VS/BLANK framing, measures line/frame geometry and
// re-emits active pixels with (x, y). Optional grid checker via VGA_RX_PATTERN_CHECK_EN.
module vga_rx #(
  parameter int HDISP = 800,
  parameter int VDISP = 480
) (
  input  logic                       pixel_clk,
  input  logic                       pixel_rst_n,
  input  logic                       vid_hs,
  input  logic                       vid_vs,
  input  logic                       vid_blank,
  input  logic [23:0]                vid_rgb,
  output logic                       pix_valid,
  output logic [$clog2(HDISP)-1:0]   pix_x,
  output logic [$clog2(VDISP)-1:0]   pix_y,
  output logic [23:0]                pix_rgb,
  output logic                       sof,
  output logic                       locked,
  output logic                       err_line,
  output logic                       err_frame,
  output logic [15:0]                frame_cnt,
  output logic                       pat_err,
  output logic [15:0]                pat_err_cnt
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int RW = $clog2(HDISP + 2);
  localparam int LW = $clog2(VDISP + 2);

  localparam logic [RW-1:0] RUN_FULL   = RW'(HDISP);
  localparam logic [RW-1:0] RUN_SAT    = RW'(HDISP + 1);
  localparam logic [LW-1:0] LINES_FULL = LW'(VDISP);
  localparam logic [LW-1:0] LINES_SAT  = LW'(VDISP + 1);
  localparam logic [XW-1:0] X_MAX      = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_MAX      = YW'(VDISP - 1);

  typedef enum logic [1:0] {SEARCH, ACQ, LOCKED} state_t;

  state_t         state_reg, state_next;
  logic           vs_q, blank_q, hs_unused_q;
  logic [RW-1:0]  run_reg, run_next, run_eff;
  logic [LW-1:0]  lines_reg, lines_next, lines_le;
  logic           bad_reg, bad_next;
  logic [15:0]    frame_cnt_reg, frame_cnt_next;
  logic           err_line_reg, err_line_next;
  logic           err_frame_reg, err_frame_next;
  logic           locked_reg;
  logic           pix_valid_reg, sof_reg, sof_next;
  logic [XW-1:0]  pix_x_reg, pix_x_next;
  logic [YW-1:0]  pix_y_reg, pix_y_next;
  logic [23:0]    pix_rgb_reg;
  logic           fb, ls, le, line_err, frame_good, active_ok;

  always_comb begin
    fb = vs_q & ~vid_vs;
    ls = ~blank_q & vid_blank;
    le = blank_q & ~vid_blank;

    // A new run restarts from zero in its first active cycle; otherwise the
    // previous count is held so it is still available at line end.
    run_eff  = ls ? '0 : run_reg;
    run_next = run_reg;
    if (vid_blank)
      run_next = (run_eff >= RUN_SAT) ? RUN_SAT : run_eff + RW'(1);

    line_err   = le && (run_reg != RUN_FULL);
    lines_le   = (le && (lines_reg != LINES_SAT)) ? lines_reg + LW'(1) : lines_reg;
    frame_good = ~bad_reg & ~line_err & (lines_le == LINES_FULL);

    pix_x_next = (run_eff >= RUN_FULL) ? X_MAX : run_eff[XW-1:0];
    pix_y_next = (lines_reg >= LINES_FULL) ? Y_MAX : lines_reg[YW-1:0];
    active_ok  = vid_blank && (state_reg != SEARCH) &&
                 (run_eff < RUN_FULL) && (lines_reg < LINES_FULL);
    sof_next   = active_ok && (state_reg == LOCKED) &&
                 (pix_x_next == '0) && (pix_y_next == '0);
  end

  always_comb begin
    state_next     = state_reg;
    lines_next     = lines_reg;
    bad_next       = bad_reg;
    frame_cnt_next = frame_cnt_reg;
    err_line_next  = 1'b0;
    err_frame_next = 1'b0;
    case (state_reg)
      SEARCH: begin
        if (fb) begin
          state_next = ACQ;
          lines_next = '0;
          bad_next   = 1'b0;
        end
      end
      ACQ, LOCKED: begin
        // The line ending in the FB cycle belongs to the frame being judged.
        lines_next    = lines_le;
        bad_next      = bad_reg | line_err;
        err_line_next = line_err;
        if (fb) begin
          lines_next = '0;
          bad_next   = 1'b0;
          if (state_reg == ACQ) begin
            if (frame_good)
              state_next = LOCKED;
          end else if (frame_good) begin
            frame_cnt_next = frame_cnt_reg + 16'd1;
          end else begin
            err_frame_next = 1'b1;
            state_next     = ACQ;
          end
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state_reg     <= SEARCH;
      vs_q          <= 1'b0;
      blank_q       <= 1'b1;
      hs_unused_q   <= 1'b1;
      run_reg       <= '0;
      lines_reg     <= '0;
      bad_reg       <= 1'b0;
      frame_cnt_reg <= '0;
      err_line_reg  <= 1'b0;
      err_frame_reg <= 1'b0;
      locked_reg    <= 1'b0;
      pix_valid_reg <= 1'b0;
      sof_reg       <= 1'b0;
      pix_x_reg     <= '0;
      pix_y_reg     <= '0;
      pix_rgb_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      vs_q          <= vid_vs;
      blank_q       <= vid_blank;
      hs_unused_q   <= vid_hs;
      run_reg       <= run_next;
      lines_reg     <= lines_next;
      bad_reg       <= bad_next;
      frame_cnt_reg <= frame_cnt_next;
      err_line_reg  <= err_line_next;
      err_frame_reg <= err_frame_next;
      locked_reg    <= (state_next == LOCKED);
      pix_valid_reg <= active_ok;
      sof_reg       <= sof_next;
      if (active_ok) begin
        pix_x_reg   <= pix_x_next;
        pix_y_reg   <= pix_y_next;
        pix_rgb_reg <= vid_rgb;
      end
    end
  end

`ifdef VGA_RX_PATTERN_CHECK_EN
  logic        pat_err_reg, pat_err_next;
  logic [15:0] pat_cnt_reg, pat_cnt_next;
  logic [23:0] exp_rgb;

  always_comb begin
    exp_rgb = (((32'(pix_x_next) & 32'hF) == 32'h0) || ((32'(pix_y_next) & 32'hF) == 32'h0))
              ? 24'hFFFFFF : 24'h000000;
    pat_err_next = active_ok && (state_reg == LOCKED) && (vid_rgb != exp_rgb);
    pat_cnt_next = pat_cnt_reg;
    if (fb)
      pat_cnt_next = '0;
    else if (pat_err_next && (pat_cnt_reg != 16'hFFFF))
      pat_cnt_next = pat_cnt_reg + 16'd1;
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      pat_err_reg <= 1'b0;
      pat_cnt_reg <= '0;
    end else begin
      pat_err_reg <= pat_err_next;
      pat_cnt_reg <= pat_cnt_next;
    end
  end

  assign pat_err     = pat_err_reg;
  assign pat_err_cnt = pat_cnt_reg;
`else
  assign pat_err     = 1'b0;
  assign pat_err_cnt = 16'h0000;
`endif

  assign pix_valid = pix_valid_reg;
  assign pix_x     = pix_x_reg;
  assign pix_y     = pix_y_reg;
  assign pix_rgb   = pix_rgb_reg;
  assign sof       = sof_reg;
  assign locked    = locked_reg;
  assign err_line  = err_line_reg;
  assign err_frame = err_frame_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx on a reduced 32x20 geometry (44 x 26 totals) driving
// a grid-pattern video stream; pattern-check tests follow VGA_RX_PATTERN_CHECK_EN.
module tb_vga_rx;
  localparam int HD = 32;
  localparam int VD = 20;
  localparam int HT = HD + 12;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst_n = 1'b0;
  logic        vid_hs = 1'b1, vid_vs = 1'b1, vid_blank = 1'b0;
  logic [23:0] vid_rgb = '0;
  logic        pix_valid, sof, locked, err_line, err_frame, pat_err;
  logic [4:0]  pix_x, pix_y;
  logic [23:0] pix_rgb;
  logic [15:0] frame_cnt, pat_err_cnt;

  vga_rx #(.HDISP(HD), .VDISP(VD)) dut (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_blank(vid_blank), .vid_rgb(vid_rgb),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .sof(sof), .locked(locked), .err_line(err_line), .err_frame(err_frame),
    .frame_cnt(frame_cnt), .pat_err(pat_err), .pat_err_cnt(pat_err_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int n_valid = 0, max_x = 0, n_sof = 0, n_sof_bad = 0;
  int n_err_line = 0, n_err_frame = 0, n_pat_err = 0;
  int err_line_edge = -1, err_frame_edge = -1, locked_rise_edge = -1;
  int fb_edge = -1, last_le_edge = -1, special_le_edge = -1;
  logic [10:0] pat_err_at = '0;
  logic locked_q = 1'b0;
  bit corrupt = 1'b0;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge pixel_clk) begin
    if (pix_valid) begin
      n_valid++;
      if (int'(pix_x) > max_x) max_x = int'(pix_x);
    end
    if (sof) begin
      n_sof++;
      if (!pix_valid || pix_x != 0 || pix_y != 0) n_sof_bad++;
    end
    if (err_line) begin n_err_line++; err_line_edge = cyc; end
    if (err_frame) begin n_err_frame++; err_frame_edge = cyc; end
    if (pat_err) begin n_pat_err++; pat_err_at = {pix_valid, pix_x, pix_y}; end
    if (locked && !locked_q) locked_rise_edge = cyc;
    locked_q = locked;
  end

  function automatic logic [23:0] grid(int x, int y);
    if (corrupt && x == 5 && y == 5) return 24'h000001;
    return ((x % 16 == 0) || (y % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
  endfunction

  task automatic drive(input logic hs, input logic vs, input logic blank, input logic [23:0] rgb);
    @(negedge pixel_clk);
    vid_hs = hs; vid_vs = vs; vid_blank = blank; vid_rgb = rgb;
  endtask

  task automatic settle();
    @(negedge pixel_clk);
    #1;
  endtask

  task automatic drive_line_from(input int x0, input int len, input int y);
    for (int x = x0; x < len; x++) drive(1'b1, 1'b1, 1'b1, grid(x, y));
    drive(1'b1, 1'b1, 1'b0, 24'h0);
    last_le_edge = cyc + 1;
    for (int i = 1; i < 12; i++) drive(!(i >= 4 && i < 8), 1'b1, 1'b0, 24'h0);
  endtask

  task automatic blank_line(input logic vs);
    for (int i = 0; i < HT; i++) drive(!(i >= HD + 4 && i < HD + 8), vs, 1'b0, 24'h0);
  endtask

  task automatic drive_active(input int nl, input int sidx, input int slen);
    for (int y = 0; y < nl; y++) begin
      drive_line_from(0, (y == sidx) ? slen : HD, y);
      if (y == sidx) special_le_edge = last_le_edge;
    end
  endtask

  task automatic drive_vtail();
    blank_line(1'b1); blank_line(1'b1);
    drive(1'b1, 1'b0, 1'b0, 24'h0);
    fb_edge = cyc + 1;
    for (int i = 1; i < 2 * HT; i++) drive(1'b1, 1'b0, 1'b0, 24'h0);
    blank_line(1'b1); blank_line(1'b1);
  endtask

  task automatic drive_frame(input int nl, input int sidx, input int slen);
    drive_active(nl, sidx, slen);
    drive_vtail();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge pixel_clk);
    #1;
    n_cmp++;
    if ({pix_valid, pix_x, pix_y, pix_rgb, sof, locked, err_line, err_frame, frame_cnt,
         pat_err, pat_err_cnt} !== 72'h0) begin
      $display("FAIL reset_outputs: got valid=%b locked=%b fcnt=%0d rgb=%h, expected all 0",
               pix_valid, locked, frame_cnt, pix_rgb);
      n_fail++;
    end
    @(negedge pixel_clk);
    pixel_rst_n = 1'b1;
    repeat (5) drive(1'b1, 1'b1, 1'b0, 24'h0);
    settle();
    n_cmp++;
    if ({locked, n_err_line, n_err_frame} !== {1'b0, 32'd0, 32'd0}) begin
      $display("FAIL reset_release: got locked=%b err_line=%0d err_frame=%0d, expected 0/0/0",
               locked, n_err_line, n_err_frame);
      n_fail++;
    end
    $display("test_reset done");
  endtask

  task automatic test_lock();
    drive_frame(VD, -1, 0);
    settle();
    n_cmp++;
    if (locked !== 1'b0 || n_valid !== 0) begin
      $display("FAIL lock_frame1: got locked=%b valid=%0d, expected 0/0", locked, n_valid);
      n_fail++;
    end
    drive_frame(VD, -1, 0);
    settle();
    n_cmp++;
    if (n_valid !== HD * VD) begin
      $display("FAIL acq_valid_count: got %0d, expected %0d", n_valid, HD * VD);
      n_fail++;
    end
    n_cmp++;
    if (locked !== 1'b1 || locked_rise_edge !== fb_edge) begin
      $display("FAIL lock_rise: got locked=%b edge=%0d, expected 1 at edge %0d",
               locked, locked_rise_edge, fb_edge);
      n_fail++;
    end
    n_cmp++;
    if (n_sof !== 0) begin
      $display("FAIL sof_unlocked: got %0d, expected 0", n_sof);
      n_fail++;
    end
    drive_frame(VD, -1, 0);
    settle();
    n_cmp++;
    if (frame_cnt !== 16'd1) begin
      $display("FAIL frame_cnt_first: got %0d, expected 1", frame_cnt);
      n_fail++;
    end
    n_cmp++;
    if (n_sof !== 1 || n_sof_bad !== 0) begin
      $display("FAIL sof_once: got count=%0d misplaced=%0d, expected 1/0", n_sof, n_sof_bad);
      n_fail++;
    end
    n_cmp++;
    if (n_err_line !== 0 || n_err_frame !== 0) begin
      $display("FAIL clean_errors: got line=%0d frame=%0d, expected 0/0", n_err_line, n_err_frame);
      n_fail++;
    end
    $display("test_lock done: frame_cnt=%0d", frame_cnt);
  endtask

  task automatic test_short_line();
    int el0, ef0;
    el0 = n_err_line; ef0 = n_err_frame;
    drive_frame(VD, 3, HD - 1);
    settle();
    n_cmp++;
    if (n_err_line - el0 !== 1 || err_line_edge !== special_le_edge) begin
      $display("FAIL short_err_line: got %0d pulses at edge %0d, expected 1 at edge %0d",
               n_err_line - el0, err_line_edge, special_le_edge);
      n_fail++;
    end
    n_cmp++;
    if (n_err_frame - ef0 !== 1 || err_frame_edge !== fb_edge) begin
      $display("FAIL short_err_frame: got %0d pulses at edge %0d, expected 1 at edge %0d",
               n_err_frame - ef0, err_frame_edge, fb_edge);
      n_fail++;
    end
    n_cmp++;
    if (locked !== 1'b0) begin
      $display("FAIL short_unlock: got locked=%b, expected 0", locked);
      n_fail++;
    end
    drive_frame(VD, -1, 0);
    settle();
    n_cmp++;
    if (locked !== 1'b1 || frame_cnt !== 16'd1) begin
      $display("FAIL short_relock: got locked=%b fcnt=%0d, expected 1/1", locked, frame_cnt);
      n_fail++;
    end
    $display("test_short_line done");
  endtask

  task automatic test_short_frame();
    int el0, ef0;
    el0 = n_err_line; ef0 = n_err_frame;
    drive_frame(VD - 1, -1, 0);
    settle();
    n_cmp++;
    if (n_err_frame - ef0 !== 1 || n_err_line - el0 !== 0) begin
      $display("FAIL short_frame_err: got frame=%0d line=%0d, expected 1/0",
               n_err_frame - ef0, n_err_line - el0);
      n_fail++;
    end
    n_cmp++;
    if (frame_cnt !== 16'd1 || locked !== 1'b0) begin
      $display("FAIL short_frame_cnt: got fcnt=%0d locked=%b, expected 1/0", frame_cnt, locked);
      n_fail++;
    end
    drive_frame(VD, -1, 0);
    drive_frame(VD, -1, 0);
    settle();
    n_cmp++;
    if (frame_cnt !== 16'd2 || locked !== 1'b1) begin
      $display("FAIL frame_cnt_incr: got fcnt=%0d locked=%b, expected 2/1", frame_cnt, locked);
      n_fail++;
    end
    $display("test_short_frame done");
  endtask

  task automatic test_long_line();
    int el0;
    el0 = n_err_line;
    n_valid = 0; max_x = 0;
    drive_frame(VD, 2, HD + 2);
    settle();
    n_cmp++;
    if (n_valid !== HD * VD || max_x !== HD - 1) begin
      $display("FAIL long_valid: got count=%0d max_x=%0d, expected %0d/%0d",
               n_valid, max_x, HD * VD, HD - 1);
      n_fail++;
    end
    n_cmp++;
    if (n_err_line - el0 !== 1) begin
      $display("FAIL long_err_line: got %0d, expected 1", n_err_line - el0);
      n_fail++;
    end
    drive_frame(VD, -1, 0);
    settle();
    $display("test_long_line done: locked=%b", locked);
  endtask

  task automatic test_pattern();
    int p0;
    p0 = n_pat_err;
`ifdef VGA_RX_PATTERN_CHECK_EN
    corrupt = 1'b1;
    drive_active(VD, -1, 0);
    corrupt = 1'b0;
    settle();
    n_cmp++;
    if (n_pat_err - p0 !== 1 || pat_err_at !== {1'b1, 5'd5, 5'd5}) begin
      $display("FAIL pat_err_pulse: got %0d pulses at {v,x,y}=%h, expected 1 at (5,5)",
               n_pat_err - p0, pat_err_at);
      n_fail++;
    end
    n_cmp++;
    if (pat_err_cnt !== 16'd1) begin
      $display("FAIL pat_err_cnt: got %0d, expected 1", pat_err_cnt);
      n_fail++;
    end
    drive_vtail();
    settle();
    n_cmp++;
    if (pat_err_cnt !== 16'd0) begin
      $display("FAIL pat_err_clear: got %0d, expected 0", pat_err_cnt);
      n_fail++;
    end
`else
    corrupt = 1'b1;
    drive_frame(VD, -1, 0);
    corrupt = 1'b0;
    settle();
    n_cmp++;
    if (n_pat_err - p0 !== 0 || pat_err_cnt !== 16'd0) begin
      $display("FAIL pat_tied: got pulses=%0d cnt=%0d, expected 0/0", n_pat_err - p0, pat_err_cnt);
      n_fail++;
    end
`endif
    $display("test_pattern done");
  endtask

  task automatic test_reset_midline();
    int s0;
    for (int y = 0; y < 3; y++) drive_line_from(0, HD, y);
    for (int x = 0; x < 10; x++) drive(1'b1, 1'b1, 1'b1, grid(x, 3));
    n_cmp++;
    if (pix_valid !== 1'b1 || locked !== 1'b1) begin
      $display("FAIL pre_reset: got valid=%b locked=%b, expected 1/1", pix_valid, locked);
      n_fail++;
    end
    #2 pixel_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pix_valid, pix_x, pix_y, pix_rgb, sof, locked, err_line, err_frame, frame_cnt,
         pat_err, pat_err_cnt} !== 72'h0) begin
      $display("FAIL async_reset: got valid=%b x=%0d locked=%b fcnt=%0d, expected all 0",
               pix_valid, pix_x, locked, frame_cnt);
      n_fail++;
    end
    for (int x = 10; x < 14; x++) drive(1'b1, 1'b1, 1'b1, grid(x, 3));
    pixel_rst_n = 1'b1;
    n_valid = 0;
    drive_line_from(14, HD, 3);
    for (int y = 4; y < VD; y++) drive_line_from(0, HD, y);
    drive_vtail();
    settle();
    n_cmp++;
    if (n_valid !== 0 || locked !== 1'b0) begin
      $display("FAIL post_reset_quiet: got valid=%0d locked=%b, expected 0/0", n_valid, locked);
      n_fail++;
    end
    drive_frame(VD, -1, 0);
    settle();
    n_cmp++;
    if (locked !== 1'b1 || locked_rise_edge !== fb_edge) begin
      $display("FAIL relock: got locked=%b edge=%0d, expected 1 at edge %0d",
               locked, locked_rise_edge, fb_edge);
      n_fail++;
    end
    s0 = n_sof;
    drive_frame(VD, -1, 0);
    settle();
    n_cmp++;
    if (n_sof - s0 !== 1 || frame_cnt !== 16'd1) begin
      $display("FAIL relock_frame: got sof=%0d fcnt=%0d, expected 1/1", n_sof - s0, frame_cnt);
      n_fail++;
    end
    $display("test_reset_midline done");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short_line();
    test_short_frame();
    test_long_line();
    test_pattern();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
